// File: rtl/unpack_float64.sv
// unpack_float64: classifies an IEEE-754 double and unpacks it into sign, exponent and normalized significand.
module unpack_float64 #(
  parameter logic [31:0] INVALID_FLAG = 32'd16
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [63:0] a,
  input  logic [31:0] float_exception_flag_i,
  output logic [31:0] float_exception_flag_o,
  output logic        float_exception_flag_o_ap_vld,
  output logic        zSign,
  output logic [12:0] zExp,
  output logic [63:0] zSig,
  output logic [2:0]  zClass
);
  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    DECODE = 4'b0010,
    NORM   = 4'b0100,
    DONE   = 4'b1000
  } state_t;
  state_t state_q, state_d;
  logic [63:0] a_q, a_d;
  logic [52:0] sig_q, sig_d;
  logic [12:0] exp_q, exp_d;
  logic [2:0]  cls_q, cls_d;
  logic        zsign_q, zsign_d;
  logic [12:0] zexp_q, zexp_d;
  logic [63:0] zsig_q, zsig_d;
  logic [2:0]  zcls_q, zcls_d;
  logic [10:0] e;
  logic [51:0] f;
  logic [2:0]  cls;
  logic        snan_done;
  always_comb begin
    e = a_q[62:52];
    f = a_q[51:0];
    cls = (e == 11'd0) ? ((f == 52'd0) ? 3'd0 : 3'd1) :
          (e == 11'h7ff) ? ((f == 52'd0) ? 3'd3 : f[51] ? 3'd4 : 3'd5) : 3'd2;
    state_d = state_q;
    a_d = a_q;
    sig_d = sig_q;
    exp_d = exp_q;
    cls_d = cls_q;
    zsign_d = zsign_q;
    zexp_d = zexp_q;
    zsig_d = zsig_q;
    zcls_d = zcls_q;
    case (state_q)
      IDLE: begin
        a_d = ap_start ? a : a_q;
        state_d = ap_start ? DECODE : IDLE;
      end
      DECODE: begin
        cls_d = cls;
        sig_d = (cls == 3'd2) ? {1'b1, f} : (cls == 3'd0) ? 53'd0 : {1'b0, f};
        exp_d = (cls == 3'd2) ? {2'b00, e} : (cls == 3'd0) ? 13'd0 : (cls == 3'd1) ? 13'd1 : 13'h7ff;
        state_d = (cls == 3'd1) ? NORM : DONE;
      end
      NORM: begin
        sig_d = sig_q[52] ? sig_q : sig_q << 1;
        exp_d = sig_q[52] ? exp_q : exp_q - 13'd1;
        state_d = sig_q[52] ? DONE : NORM;
      end
      DONE: begin
        zsign_d = a_q[63];
        zexp_d = exp_q;
        zsig_d = {1'b0, sig_q, 10'b0};
        zcls_d = cls_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      a_q <= '0;
      sig_q <= '0;
      exp_q <= '0;
      cls_q <= '0;
      zsign_q <= 1'b0;
      zexp_q <= '0;
      zsig_q <= '0;
      zcls_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      sig_q <= sig_d;
      exp_q <= exp_d;
      cls_q <= cls_d;
      zsign_q <= zsign_d;
      zexp_q <= zexp_d;
      zsig_q <= zsig_d;
      zcls_q <= zcls_d;
    end
  end
  assign snan_done = (state_q == DONE) && (cls_q == 3'd5);
  assign ap_idle = (state_q == IDLE) && !ap_start;
  assign ap_done = ap_idle || (state_q == DONE);
  assign ap_ready = state_q == DONE;
  assign float_exception_flag_o = float_exception_flag_i | (snan_done ? INVALID_FLAG : 32'd0);
  assign float_exception_flag_o_ap_vld = snan_done;
  assign zSign = zsign_q;
  assign zExp = zexp_q;
  assign zSig = zsig_q;
  assign zClass = zcls_q;
endmodule

// File: tb/tb_unpack_float64.sv
// tb_unpack_float64: directed vectors with hand-computed expectations for unpack_float64.
module tb_unpack_float64;
  logic        clk = 1'b0;
  logic        rst;
  logic        ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [63:0] a;
  logic [31:0] flag_i, flag_o;
  logic        flag_vld;
  logic        z_sign;
  logic [12:0] z_exp;
  logic [63:0] z_sig;
  logic [2:0]  z_class;
  int checks = 0;
  int errors = 0;

  unpack_float64 dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .ap_start(ap_start),
    .ap_done(ap_done),
    .ap_idle(ap_idle),
    .ap_ready(ap_ready),
    .a(a),
    .float_exception_flag_i(flag_i),
    .float_exception_flag_o(flag_o),
    .float_exception_flag_o_ap_vld(flag_vld),
    .zSign(z_sign),
    .zExp(z_exp),
    .zSig(z_sig),
    .zClass(z_class)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation and checks latency, flags at the done strobe, and the held outputs afterwards.
  task automatic run(input string tag, input logic [63:0] a_in, input logic [31:0] fl, input int lat,
                     input logic sgn, input logic [12:0] ze, input logic [63:0] zs, input logic [2:0] zc,
                     input logic vld);
    int cyc;
    flag_i = fl;
    a = a_in;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    cyc = 1;
    while (!ap_ready && cyc < 200) begin
      check({tag, " early_vld"}, {63'd0, flag_vld}, 64'd0);
      tick();
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " flag_o"}, {32'd0, flag_o}, {32'd0, vld ? (fl | 32'd16) : fl});
    check({tag, " vld"}, {63'd0, flag_vld}, {63'd0, vld});
    tick();
    check({tag, " idle_after"}, {63'd0, ap_idle}, 64'd1);
    check({tag, " idle_flag"}, {31'd0, flag_vld, flag_o}, {32'd0, fl});
    check({tag, " sign"}, {63'd0, z_sign}, {63'd0, sgn});
    check({tag, " exp"}, {51'd0, z_exp}, {51'd0, ze});
    check({tag, " sig"}, z_sig, zs);
    check({tag, " class"}, {61'd0, z_class}, {61'd0, zc});
  endtask

  initial begin
    logic seen_ready, seen_vld;
    rst = 1'b1;
    ap_start = 1'b0;
    a = '0;
    flag_i = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset idle", {63'd0, ap_idle}, 64'd1);
    check("reset outs", {z_sign, z_exp, z_class, z_sig[46:0]} | z_sig, 64'd0);

    run("one",     64'h3FF0000000000000, 32'h0, 2,  1'b0, 13'h3FF,  64'h4000000000000000, 3'd2, 1'b0);
    run("min_sub", 64'h0000000000000001, 32'h0, 55, 1'b0, 13'h1FCD, 64'h4000000000000000, 3'd1, 1'b0);
    run("max_sub", 64'h0008000000000000, 32'h2, 4,  1'b0, 13'h0,    64'h4000000000000000, 3'd1, 1'b0);
    run("snan",    64'h7FF4000000000000, 32'h1, 2,  1'b0, 13'h7FF,  64'h1000000000000000, 3'd5, 1'b1);
    run("qnan",    64'h7FF8000000000001, 32'h4, 2,  1'b0, 13'h7FF,  64'h2000000000000400, 3'd4, 1'b0);
    run("neg_zero",64'h8000000000000000, 32'h0, 2,  1'b1, 13'h0,    64'h0,                3'd0, 1'b0);
    run("neg_inf", 64'hFFF0000000000000, 32'h0, 2,  1'b1, 13'h7FF,  64'h0,                3'd3, 1'b0);
    run("neg_norm",64'hC00FFFFFFFFFFFFF, 32'h0, 2,  1'b1, 13'h400,  64'h7FFFFFFFFFFFFC00, 3'd2, 1'b0);

    // Abort a subnormal in its 10th NORM cycle (cycle 11 after acceptance).
    seen_ready = 1'b0;
    seen_vld = 1'b0;
    a = 64'h0000000000000001;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    for (int i = 1; i < 11; i++) begin
      seen_ready |= ap_ready;
      seen_vld |= flag_vld;
      tick();
    end
    seen_ready |= ap_ready;
    seen_vld |= flag_vld;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort idle", {63'd0, ap_idle}, 64'd1);
    check("abort no_done", {62'd0, seen_ready, seen_vld}, 64'd0);
    check("abort outs", {z_sign, z_exp, z_class, 47'd0} | z_sig, 64'd0);

    run("after_abort", 64'h3FF0000000000000, 32'h0, 2, 1'b0, 13'h3FF, 64'h4000000000000000, 3'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
